// File: rtl/imem_load_controller.sv
// Host byte-stream loader for the 64 x 16 instruction memory, sharing write port 1
// with a debug write requester. Stalls the core while a load is in progress.
module imem_load_controller #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_length,
    input  logic                  host_valid,
    input  logic [7:0]            host_data,
    output logic                  host_ready,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  dbg_grant,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [DATA_WIDTH-1:0] imem_wr_data,
    output logic                  imem_wr_enable,
    output logic                  core_stall,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_error
);
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic [7:0]            low_byte_q, low_byte_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  dbg_grant_q, dbg_grant_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  word_done;
    logic                  len_ok;

    assign host_ready = (state_q == S_LOW) || (state_q == S_HIGH);
    assign word_done  = (state_q == S_HIGH) && host_valid;
    assign len_ok     = (load_length != '0) && (load_length <= MAX_LEN);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        low_byte_d  = low_byte_q;
        error_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    if (len_ok) begin
                        addr_d      = load_base;
                        remaining_d = load_length;
                        state_d     = S_LOW;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_LOW: begin
                if (host_valid) begin
                    low_byte_d = host_data;
                    state_d    = S_HIGH;
                end
            end
            S_HIGH: begin
                if (host_valid) begin
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - ONE_LEN;
                    state_d     = (remaining_q == ONE_LEN) ? S_DONE : S_LOW;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Loader words take the port first; a debug request waits for the next bubble.
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        dbg_grant_d = 1'b0;
        if (word_done) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {host_data, low_byte_q};
        end else if (dbg_req && !dbg_grant_q) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = dbg_addr;
            wr_data_d   = dbg_data;
            dbg_grant_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            low_byte_q  <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            dbg_grant_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            low_byte_q  <= low_byte_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            dbg_grant_q <= dbg_grant_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign imem_wr_addr   = wr_addr_q;
    assign imem_wr_data   = wr_data_q;
    assign imem_wr_enable = wr_en_q;
    assign dbg_grant      = dbg_grant_q;
    assign core_stall     = busy_q;
    assign load_busy      = busy_q;
    assign load_done      = done_q;
    assign load_error     = error_q;
endmodule

// File: tb/tb_imem_load_controller.sv
// Vector-table bench for imem_load_controller: each row drives one cycle of inputs
// and lists the outputs expected after that rising edge.
module tb_imem_load_controller;
    logic        clock;
    logic        reset;
    logic        load_start;
    logic [5:0]  load_base;
    logic [6:0]  load_length;
    logic        host_valid;
    logic [7:0]  host_data;
    logic        host_ready;
    logic        dbg_req;
    logic [5:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic        dbg_grant;
    logic [5:0]  imem_wr_addr;
    logic [15:0] imem_wr_data;
    logic        imem_wr_enable;
    logic        core_stall;
    logic        load_busy;
    logic        load_done;
    logic        load_error;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_count = 0;

    typedef struct {
        logic        ls;
        logic [5:0]  base;
        logic [6:0]  len;
        logic        hv;
        logic [7:0]  hd;
        logic        dr;
        logic [5:0]  da;
        logic [15:0] dd;
        logic [28:0] exp;
    } vec_t;

    vec_t tbl[$];

    imem_load_controller dut (
        .clock(clock),
        .reset(reset),
        .load_start(load_start),
        .load_base(load_base),
        .load_length(load_length),
        .host_valid(host_valid),
        .host_data(host_data),
        .host_ready(host_ready),
        .dbg_req(dbg_req),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .dbg_grant(dbg_grant),
        .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data),
        .imem_wr_enable(imem_wr_enable),
        .core_stall(core_stall),
        .load_busy(load_busy),
        .load_done(load_done),
        .load_error(load_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (imem_wr_enable) wr_count <= wr_count + 1;
    end

    // Packing order: host_ready, wr_en, wr_addr, wr_data, grant, stall, busy, done, error.
    function automatic logic [28:0] e(input logic hr, input logic we, input logic [5:0] wa,
                                      input logic [15:0] wd, input logic dg, input logic cs,
                                      input logic lb, input logic ld, input logic le);
        return {hr, we, wa, wd, dg, cs, lb, ld, le};
    endfunction

    function automatic logic [28:0] outs();
        return {host_ready, imem_wr_enable, imem_wr_addr, imem_wr_data, dbg_grant,
                core_stall, load_busy, load_done, load_error};
    endfunction

    function automatic vec_t mk(input logic ls, input logic [5:0] base, input logic [6:0] len,
                                input logic hv, input logic [7:0] hd, input logic dr,
                                input logic [5:0] da, input logic [15:0] dd,
                                input logic [28:0] exp);
        vec_t v;
        v.ls = ls; v.base = base; v.len = len; v.hv = hv; v.hd = hd;
        v.dr = dr; v.da = da; v.dd = dd; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        load_start = 1'b0; load_base = '0; load_length = '0;
        host_valid = 1'b0; host_data = '0;
        dbg_req = 1'b0; dbg_addr = '0; dbg_data = '0;
    endtask

    // Called at a falling edge: drive the row, let one rising edge pass, check at the next fall.
    task automatic cyc(input vec_t v, input string name);
        load_start = v.ls; load_base = v.base; load_length = v.len;
        host_valid = v.hv; host_data = v.hd;
        dbg_req = v.dr; dbg_addr = v.da; dbg_data = v.dd;
        @(negedge clock);
        check(name, {3'b0, outs()}, {3'b0, v.exp});
        $display("%s: outs=%h exp=%h", name, outs(), v.exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base_cnt;
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clock);
        check("in_reset", {3'b0, outs()}, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("after_reset", {3'b0, outs()}, 32'h0);

        // Basic two-word load at base 0.
        tbl.push_back(mk(1, 0, 2, 0, 8'h00, 0, 0, 0, e(1, 0, 0, 16'h0000, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 1, 8'h34, 0, 0, 0, e(1, 0, 0, 16'h0000, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 1, 8'h12, 0, 0, 0, e(1, 1, 0, 16'h1234, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 1, 8'h78, 0, 0, 0, e(1, 0, 0, 16'h1234, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 1, 8'h56, 0, 0, 0, e(0, 1, 1, 16'h5678, 0, 1, 1, 1, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, e(0, 0, 1, 16'h5678, 0, 0, 0, 0, 0)));
        // Wrapping load base 62, four words; a load_start mid-load is ignored.
        tbl.push_back(mk(1, 62, 4, 0, 8'h00, 0, 0, 0, e(1, 0, 1, 16'h5678, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 1, 8'h01, 0, 0, 0, e(1, 0, 1, 16'h5678, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0, e(1, 1, 62, 16'h0001, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(1, 10, 3, 1, 8'h02, 0, 0, 0, e(1, 0, 62, 16'h0001, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0, e(1, 1, 63, 16'h0002, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 1, 8'h03, 0, 0, 0, e(1, 0, 63, 16'h0002, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0, e(1, 1, 0, 16'h0003, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 1, 8'h04, 0, 0, 0, e(1, 0, 0, 16'h0003, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0, e(0, 1, 1, 16'h0004, 0, 1, 1, 1, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, e(0, 0, 1, 16'h0004, 0, 0, 0, 0, 0)));
        // Rejected lengths 0 and 65.
        tbl.push_back(mk(1, 7, 0, 0, 8'h00, 0, 0, 0, e(0, 0, 1, 16'h0004, 0, 0, 0, 0, 1)));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, e(0, 0, 1, 16'h0004, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 7, 65, 0, 8'h00, 0, 0, 0, e(0, 0, 1, 16'h0004, 0, 0, 0, 0, 1)));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, e(0, 0, 1, 16'h0004, 0, 0, 0, 0, 0)));
        // Host gaps 1,0,0,1 on a one-word load at base 20.
        tbl.push_back(mk(1, 20, 1, 0, 8'h00, 0, 0, 0, e(1, 0, 1, 16'h0004, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 1, 8'hCD, 0, 0, 0, e(1, 0, 1, 16'h0004, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 8'h99, 0, 0, 0, e(1, 0, 1, 16'h0004, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 8'h77, 0, 0, 0, e(1, 0, 1, 16'h0004, 0, 1, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 1, 8'hAB, 0, 0, 0, e(0, 1, 20, 16'hABCD, 0, 1, 1, 1, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, e(0, 0, 20, 16'hABCD, 0, 0, 0, 0, 0)));
        // Unconflicted debug write, request held across the grant cycle.
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 5, 16'hBEEF, e(0, 1, 5, 16'hBEEF, 1, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 5, 16'hBEEF, e(0, 0, 5, 16'hBEEF, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 16'h0000, e(0, 0, 5, 16'hBEEF, 0, 0, 0, 0, 0)));

        foreach (tbl[i]) cyc(tbl[i], $sformatf("row%0d", i));

        // Debug request arriving with a loader high-byte handshake: loader first, debug next.
        base_cnt = wr_count;
        cyc(mk(1, 40, 2, 0, 8'h00, 0, 0, 0, e(1, 0, 5, 16'hBEEF, 0, 1, 1, 0, 0)), "conf_start");
        cyc(mk(0, 0, 0, 1, 8'h11, 0, 0, 0, e(1, 0, 5, 16'hBEEF, 0, 1, 1, 0, 0)), "conf_low");
        cyc(mk(0, 0, 0, 1, 8'h22, 1, 5, 16'hBEEF, e(1, 1, 40, 16'h2211, 0, 1, 1, 0, 0)), "conf_loader_wr");
        cyc(mk(0, 0, 0, 0, 8'h00, 1, 5, 16'hBEEF, e(1, 1, 5, 16'hBEEF, 1, 1, 1, 0, 0)), "conf_dbg_wr");
        cyc(mk(0, 0, 0, 0, 8'h00, 1, 5, 16'hBEEF, e(1, 0, 5, 16'hBEEF, 0, 1, 1, 0, 0)), "conf_held");
        cyc(mk(0, 0, 0, 1, 8'h33, 0, 0, 0, e(1, 0, 5, 16'hBEEF, 0, 1, 1, 0, 0)), "conf_low2");
        cyc(mk(0, 0, 0, 1, 8'h44, 0, 0, 0, e(0, 1, 41, 16'h4433, 0, 1, 1, 1, 0)), "conf_done");
        cyc(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, e(0, 0, 41, 16'h4433, 0, 0, 0, 0, 0)), "conf_idle");
        @(negedge clock);
        check("conf_write_count", 32'(wr_count - base_cnt), 32'd3);

        // Asynchronous reset after the low byte of word 3 of 4.
        base_cnt = wr_count;
        cyc(mk(1, 8, 4, 0, 8'h00, 0, 0, 0, e(1, 0, 41, 16'h4433, 0, 1, 1, 0, 0)), "rst_start");
        cyc(mk(0, 0, 0, 1, 8'h01, 0, 0, 0, e(1, 0, 41, 16'h4433, 0, 1, 1, 0, 0)), "rst_w1l");
        cyc(mk(0, 0, 0, 1, 8'h0A, 0, 0, 0, e(1, 1, 8, 16'h0A01, 0, 1, 1, 0, 0)), "rst_w1h");
        cyc(mk(0, 0, 0, 1, 8'h02, 0, 0, 0, e(1, 0, 8, 16'h0A01, 0, 1, 1, 0, 0)), "rst_w2l");
        cyc(mk(0, 0, 0, 1, 8'h0B, 0, 0, 0, e(1, 1, 9, 16'h0B02, 0, 1, 1, 0, 0)), "rst_w2h");
        cyc(mk(0, 0, 0, 1, 8'h03, 0, 0, 0, e(1, 0, 9, 16'h0B02, 0, 1, 1, 0, 0)), "rst_w3l");
        drive_idle();
        host_valid = 1'b1;
        host_data = 8'h0C;
        reset = 1'b1;
        #1;
        check("rst_immediate", {3'b0, outs()}, 32'h0);
        $display("rst_immediate: outs=%h", outs());
        repeat (2) @(negedge clock);
        check("rst_held", {3'b0, outs()}, 32'h0);
        check("rst_write_count", 32'(wr_count - base_cnt), 32'd2);
        drive_idle();
        reset = 1'b0;
        cyc(mk(1, 0, 1, 0, 8'h00, 0, 0, 0, e(1, 0, 0, 16'h0000, 0, 1, 1, 0, 0)), "post_start");
        cyc(mk(0, 0, 0, 1, 8'h0B, 0, 0, 0, e(1, 0, 0, 16'h0000, 0, 1, 1, 0, 0)), "post_low");
        cyc(mk(0, 0, 0, 1, 8'h0A, 0, 0, 0, e(0, 1, 0, 16'h0A0B, 0, 1, 1, 1, 0)), "post_done");
        cyc(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, e(0, 0, 0, 16'h0A0B, 0, 0, 0, 0, 0)), "post_idle");
        check("post_write_count", 32'(wr_count - base_cnt), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_load_controller.md
# imem_load_controller

Sequences host-driven loading of the 64 x 16 instruction memory through its write port 1 and shares that port with a debug write requester. It assembles a byte stream (low byte first) into 16-bit words, writes them at consecutive wrapping addresses from a base, and stalls the core for the duration of a load. It sits between the host/debug interfaces and the instruction memory write port 1 signals (address, data, enable).

## Interface
- ADDR_WIDTH, 6, instruction memory address width
- DATA_WIDTH, 16, instruction word width
- DEPTH, 64, number of words; maximum load length
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- load_start  input  1  one-cycle request to begin a load; sampled only in IDLE
- load_base  input  6  first word address, captured with load_start
- load_length  input  7  word count, captured with load_start; legal 1..64
- host_valid  input  1  host byte available
- host_data  input  8  host byte
- host_ready  output  1  controller accepts the byte this cycle
- dbg_req  input  1  debug write request, held until granted
- dbg_addr  input  6  debug write address
- dbg_data  input  16  debug write data
- dbg_grant  output  1  one-cycle pulse, coincident with the debug write
- imem_wr_addr  output  6  to instruction memory write port 1 address
- imem_wr_data  output  16  to instruction memory write port 1 data
- imem_wr_enable  output  1  to instruction memory write port 1 enable
- core_stall  output  1  high while a load is in progress
- load_busy  output  1  high in any state other than IDLE
- load_done  output  1  one-cycle pulse on load completion
- load_error  output  1  one-cycle pulse on rejected load_start

## Operation
- Reset: all outputs 0, state IDLE, counters and byte holding register 0.
- States: IDLE, LOW, HIGH, DONE.
- IDLE: load_start with 1 <= load_length <= 64 -> capture base/length, go to LOW. load_start with length 0 or >64 -> load_error=1 next cycle, stay in IDLE.
- LOW: host_ready=1; on host_valid & host_ready capture host_data as bits [7:0], go to HIGH.
- HIGH: host_ready=1; on the handshake form word {host_data, low byte}, register a loader write, decrement the remaining count. If remaining was 1, go to DONE; otherwise go to LOW.
- DONE: load_done=1 for one cycle, then IDLE.
- Address: starts at load_base and increments by 1 per written word, modulo 64 (63 -> 0).
- load_start outside IDLE is ignored with no error.
- Write port arbitration is evaluated at each rising edge:
  - A loader word completing this cycle wins: imem_wr_enable=1 next cycle with the loader address and data.
  - Otherwise, if dbg_req=1 and dbg_grant=0: register the debug write, and dbg_grant=1 in the same cycle as imem_wr_enable.
  - dbg_req is not sampled while dbg_grant=1. A held request therefore produces exactly one write.
  - Debug writes are permitted during a load, in any bubble cycle.
- imem_wr_enable is high for exactly one cycle per write. imem_wr_addr and imem_wr_data hold their last values when enable=0.

## Timing
- All outputs are registered except host_ready, which is a decode of the current state (LOW or HIGH).
- core_stall and load_busy rise in the cycle after an accepted load_start and fall in the cycle after DONE.
- Memory write latency: the word is written one cycle after its high-byte handshake. The final write coincides with the DONE cycle.
- Minimum load time: 2N + 1 cycles after load_start for N words, with host_valid held high.
- Debug grant latency: 1 cycle when there is no loader conflict. Each loader word adds at most 1 cycle of delay, since the loader has no more than 1 word per 2 cycles.
- Asynchronous reset mid-load: immediately returns to IDLE with all outputs 0. A partially assembled word is discarded and no write is issued.
- Host stalls (host_valid=0) hold state indefinitely. There is no timeout.

## Test plan
- Reset, then load_start with base=0, length=2, bytes 34,12,78,56 back-to-back -> writes 0x1234@0 then 0x5678@1, load_done pulses at cycle 5 after start, core_stall high for cycles 1..5.
- Wrap: base=62, length=4, words 0x0001..0x0004 -> writes at addresses 62, 63, 0, 1 in order.
- Errors: load_start with length=0 and then length=65 -> load_error pulses each time, load_busy stays 0, no writes; load_start during an active load -> ignored.
- Conflict: dbg_req=1 (addr 5, data 0xBEEF) asserted in the same cycle as a loader high-byte handshake -> loader write first, debug write next cycle with dbg_grant=1; held dbg_req yields exactly one write.
- Host gaps: host_valid toggles 1,0,0,1 -> state holds, host_ready stays 1, resulting word is correct, and no spurious imem_wr_enable occurs.
- Reset asserted after the low byte of word 3 of 4 -> outputs 0 at once, no third write, next load from IDLE completes normally.
